// File: rtl/mem_responder.sv
//-----------------------------------------------------------------------------
// mem_responder
//
// Single-outstanding memory target. A request is granted combinationally
// when the responder is IDLE (or presenting its previous response in RESP).
// Writes update storage at the granting edge and reads sample storage at the
// granting edge. The response is a one-cycle rvalid_o pulse issued
// WAIT_CYCLES+1 cycles after the grant.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words of storage (power of two, 16..4096)
//   WAIT_CYCLES : extra cycles between grant and response (0..15)
//   BASE_ADDR   : byte address that maps to word 0
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   req_i     in   initiator request
//   addr_i    in   byte address (bits [1:0] ignored)
//   we_i      in   1 = write, 0 = read
//   be_i      in   write byte enables
//   wdata_i   in   write data
//   gnt_o     out  request accepted this cycle (combinational)
//   rvalid_o  out  one-cycle response pulse
//   rdata_o   out  read data (zero unless a read response is valid)
//   err_o     out  response error (valid with rvalid_o)
//
// Build option
//   MEM_RESP_ERROR_EN : when defined, word indices at or beyond DEPTH_WORDS
//                       are errored (write suppressed, rdata 0, err_o 1).
//                       When undefined, the index wraps modulo DEPTH_WORDS
//                       and err_o is always 0.
//-----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         AW          = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_hold_data;
    logic          r_hold_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_gnt;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic [31:0]   w_rsp_data;

    // Word index from byte address, 32-bit unsigned arithmetic.
`ifdef MEM_RESP_ERROR_EN
    logic [31:0] w_word;
    assign w_word = (addr_i - BASE_ADDR) >> 2;
    assign w_idx  = w_word[AW-1:0];
    assign w_oor  = (w_word >= DEPTH_WORDS);
`else
    // Truncating to AW bits gives the modulo-DEPTH_WORDS wrap.
    assign w_idx  = AW'((addr_i - BASE_ADDR) >> 2);
    assign w_oor  = 1'b0;
`endif

    // Accept only when no response is pending beyond this cycle.
    assign w_gnt = req_i && ((r_state == IDLE) || (r_state == RESP)) && !reset;

    // Write responses and errored accesses carry zero data.
    assign w_rsp_data = (we_i || w_oor) ? 32'h0 : r_mem[w_idx];

    // Storage has no reset; w_gnt already excludes reset.
    always_ff @(posedge clk) begin
        if (w_gnt && we_i && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_rvalid    <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_hold_data <= 32'h0;
            r_hold_err  <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses by default.
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;

            case (r_state)
                IDLE, RESP: begin
                    if (w_gnt) begin
                        r_hold_data <= w_rsp_data;
                        r_hold_err  <= w_oor;
                        if (WAIT_CYCLES == 0) begin
                            r_state  <= RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_rsp_data;
                            r_err    <= w_oor;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= C_WAIT_LOAD;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end

                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_hold_data;
                        r_err    <= r_hold_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule
